// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/mem/writeback
// for a shared-memory datapath, with memory handshake timeout and illegal-opcode flagging.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int HAS_BNE     = 1,
  parameter int HAS_JAL     = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       branch_ne,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       link,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_IMMEX   = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // Last waiting cycle before a bus error; unused when MEM_TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            in_mem, timeout;
  logic            is_imm, is_bne, is_jal;

  assign is_imm = (op[5:3] == 3'b001);
  assign is_bne = (HAS_BNE != 0) && (op == OP_BNE);
  assign is_jal = (HAS_JAL != 0) && (op == OP_JAL);

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = (MEM_TIMEOUT != 0) && in_mem && !mem_ready && (to_cnt_q == TO_LAST);

  // Count only cycles spent waiting in a memory state; any exit or ready clears it.
  assign to_cnt_d = (in_mem && !mem_ready && !timeout) ? to_cnt_q + 1'b1 : '0;
  assign state_o  = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_FETCH;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    branch_ne   = 1'b0;
    pcsrc       = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    link        = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    bus_err     = 1'b0;
    // Outputs stay forced low for as long as reset is held, independent of the clock.
    if (resetn) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
          bus_err = timeout;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          if (op == OP_R)                      state_d = S_EXEC;
          else if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
          else if (is_imm)                     state_d = S_IMMEX;
          else if (op == OP_BEQ || is_bne)     state_d = S_BRANCH;
          else if (op == OP_J || is_jal)       state_d = S_JUMP;
          else                                 state_d = S_ILLEGAL;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          bus_err = timeout;
          if (mem_ready)    state_d = S_MEMWB;
          else if (timeout) state_d = S_FETCH;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
          bus_err    = timeout;
          if (mem_ready || timeout) state_d = S_FETCH;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = 2'b11;
          state_d = S_IMMWB;
        end
        S_IMMWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcwritecond = 1'b1;
          pcsrc       = 2'b01;
          branch_ne   = (op == OP_BNE);
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          pcwrite    = 1'b1;
          pcsrc      = 2'b10;
          regwrite   = is_jal;
          link       = is_jal;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_ILLEGAL: begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
